// File: rtl/vga_mode_pkg.sv
// Shared definitions for the VGA mode controller: mode indices, the
// built-in timing table and the controller state encoding.
package vga_mode_pkg;

  localparam logic [1:0] MODE_640x480   = 2'd0;
  localparam logic [1:0] MODE_800x600   = 2'd1;
  localparam logic [1:0] MODE_1024x768  = 2'd2;
  localparam logic [1:0] MODE_1280x1024 = 2'd3;

  // Complete parameter set handed to the timing generator.
  typedef struct packed {
    logic [11:0] h_disp;
    logic [11:0] h_fporch;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] v_disp;
    logic [11:0] v_fporch;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
  } timing_t;

  localparam timing_t TIMING_640x480 = '{
    h_disp: 12'd640,  h_fporch: 12'd16, h_sync: 12'd96,  h_bporch: 12'd48,
    v_disp: 12'd480,  v_fporch: 12'd10, v_sync: 12'd2,   v_bporch: 12'd33
  };
  localparam timing_t TIMING_800x600 = '{
    h_disp: 12'd800,  h_fporch: 12'd40, h_sync: 12'd128, h_bporch: 12'd88,
    v_disp: 12'd600,  v_fporch: 12'd1,  v_sync: 12'd4,   v_bporch: 12'd23
  };
  localparam timing_t TIMING_1024x768 = '{
    h_disp: 12'd1024, h_fporch: 12'd24, h_sync: 12'd136, h_bporch: 12'd160,
    v_disp: 12'd768,  v_fporch: 12'd3,  v_sync: 12'd6,   v_bporch: 12'd29
  };
  localparam timing_t TIMING_1280x1024 = '{
    h_disp: 12'd1280, h_fporch: 12'd48, h_sync: 12'd112, h_bporch: 12'd248,
    v_disp: 12'd1024, v_fporch: 12'd1,  v_sync: 12'd3,   v_bporch: 12'd38
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_APPLY,
    ST_SETTLE,
    ST_ACK
  } state_t;

endpackage

// File: rtl/vga_vs_sync_edge.sv
// Brings the generator's active-low vsync into the pixel clock domain and
// emits a one-cycle pulse on each synchronized falling edge.
module vga_vs_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vs_i,
  output logic vs_fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Two-flop synchronizer plus history flop; reset high (vsync idle level)
  // so that releasing reset never fakes a falling edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift as one
      // pipeline; blocking ones would collapse them into a single stage.
      meta_q <= vs_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign vs_fall_o = hist_q & ~sync_q;

endmodule

// File: rtl/vga_mode_controller.sv
// Sequences video-mode changes: swaps the full timing parameter set during
// vertical sync, blanks the display for a settle period, and reports
// completion over a four-phase req/ack handshake.
module vga_mode_controller
  import vga_mode_pkg::*;
#(
  parameter int RESET_MODE     = 0,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  output logic        mode_ack,
  output logic        busy,
  output logic [1:0]  current_mode,
  input  logic        vga_vs,
  output logic [11:0] h_disp,
  output logic [11:0] h_fporch,
  output logic [11:0] h_sync,
  output logic [11:0] h_bporch,
  output logic [11:0] v_disp,
  output logic [11:0] v_fporch,
  output logic [11:0] v_sync,
  output logic [11:0] v_bporch,
  output logic        blank_force,
  output logic        timeout_flag
);

  function automatic timing_t mode_timing(input logic [1:0] mode);
    timing_t t;
    case (mode)
      MODE_640x480:  t = TIMING_640x480;
      MODE_800x600:  t = TIMING_800x600;
      MODE_1024x768: t = TIMING_1024x768;
      default:       t = TIMING_1280x1024;
    endcase
    return t;
  endfunction

  localparam logic [1:0]  RESET_IDX    = 2'(RESET_MODE);
  localparam timing_t     RESET_TIMING = mode_timing(RESET_IDX);
  localparam logic [3:0]  SETTLE_LAST  = 4'(SETTLE_FRAMES);
  localparam logic [23:0] TMO_LAST     = 24'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  mode_q, mode_d;
  timing_t     timing_q, timing_d;
  logic [3:0]  frame_q, frame_d;
  logic [23:0] tmo_q, tmo_d;
  logic        tflag_q, tflag_d;
  logic        boot_q, boot_d;   // settle after reset ends in IDLE, not ACK
  logic        tmo_hit;
  logic        vs_fall;

  vga_vs_sync_edge u_vs_sync (
    .clk_i     (pixel_clk),
    .rst_n_i   (reset_n),
    .vs_i      (vga_vs),
    .vs_fall_o (vs_fall)
  );

  // State and datapath registers; reset reloads the power-on mode and starts
  // a settle period so the generator sees a clean, blanked start.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SETTLE;
      pending_q <= RESET_IDX;
      mode_q    <= RESET_IDX;
      timing_q  <= RESET_TIMING;
      frame_q   <= '0;
      tmo_q     <= '0;
      tflag_q   <= 1'b0;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      timing_q  <= timing_d;
      frame_q   <= frame_d;
      tmo_q     <= tmo_d;
      tflag_q   <= tflag_d;
      boot_q    <= boot_d;
    end
  end

  // Next-state logic: handshake acceptance, vsync/timeout waits, atomic
  // table load in APPLY and frame counting in SETTLE.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    timing_d  = timing_q;
    frame_d   = frame_q;
    tmo_d     = tmo_q;
    tflag_d   = tflag_q;
    boot_d    = boot_q;
    tmo_hit   = (tmo_q == TMO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (mode_req && !mode_ack) begin
          pending_d = mode_sel;
          tflag_d   = 1'b0;
          state_d   = (mode_sel == mode_q) ? ST_ACK : ST_WAIT_VS;
        end
      end

      ST_WAIT_VS: begin
        if (vs_fall || tmo_hit) begin
          tmo_d   = '0;
          state_d = ST_APPLY;
          if (!vs_fall) tflag_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

      // A vsync edge landing here is deliberately ignored.
      ST_APPLY: begin
        timing_d = mode_timing(pending_q);
        mode_d   = pending_q;
        frame_d  = '0;
        tmo_d    = '0;
        state_d  = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (vs_fall || tmo_hit) begin
          tmo_d   = '0;
          frame_d = frame_q + 4'd1;
          if (!vs_fall) tflag_d = 1'b1;
          if (frame_q + 4'd1 == SETTLE_LAST) begin
            state_d = boot_q ? ST_IDLE : ST_ACK;
            boot_d  = 1'b0;
          end
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end

      ST_ACK: begin
        if (!mode_req) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mode_ack     = (state_q == ST_ACK);
  assign busy         = (state_q != ST_IDLE);
  assign blank_force  = (state_q == ST_SETTLE);
  assign current_mode = mode_q;
  assign timeout_flag = tflag_q;

  assign h_disp   = timing_q.h_disp;
  assign h_fporch = timing_q.h_fporch;
  assign h_sync   = timing_q.h_sync;
  assign h_bporch = timing_q.h_bporch;
  assign v_disp   = timing_q.v_disp;
  assign v_fporch = timing_q.v_fporch;
  assign v_sync   = timing_q.v_sync;
  assign v_bporch = timing_q.v_bporch;

endmodule

// File: tb/tb_vga_mode_controller.sv
// Self-checking bench for vga_mode_controller: directed handshake, timeout
// and reset scenarios followed by randomized mode changes, all checked
// against a transaction-level model of the mode table and vsync latencies.
module tb_vga_mode_controller;

  localparam int T_CYC  = 1000;
  localparam int SETTLE = 2;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic        mode_ack;
  logic        busy;
  logic [1:0]  current_mode;
  logic        vga_vs;
  logic [11:0] h_disp, h_fporch, h_sync, h_bporch;
  logic [11:0] v_disp, v_fporch, v_sync, v_bporch;
  logic        blank_force;
  logic        timeout_flag;

  vga_mode_controller #(
    .RESET_MODE     (0),
    .SETTLE_FRAMES  (SETTLE),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .pixel_clk    (pixel_clk),
    .reset_n      (reset_n),
    .mode_req     (mode_req),
    .mode_sel     (mode_sel),
    .mode_ack     (mode_ack),
    .busy         (busy),
    .current_mode (current_mode),
    .vga_vs       (vga_vs),
    .h_disp       (h_disp),
    .h_fporch     (h_fporch),
    .h_sync       (h_sync),
    .h_bporch     (h_bporch),
    .v_disp       (v_disp),
    .v_fporch     (v_fporch),
    .v_sync       (v_sync),
    .v_bporch     (v_bporch),
    .blank_force  (blank_force),
    .timeout_flag (timeout_flag)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Reference mode table.
  int exp_hd[4] = '{640, 800, 1024, 1280};
  int exp_hf[4] = '{16, 40, 24, 48};
  int exp_hs[4] = '{96, 128, 136, 112};
  int exp_hb[4] = '{48, 88, 160, 248};
  int exp_vd[4] = '{480, 600, 768, 1024};
  int exp_vf[4] = '{10, 1, 3, 1};
  int exp_vs[4] = '{2, 4, 6, 3};
  int exp_vb[4] = '{33, 23, 29, 38};

  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int exp_mode   = 0;
  int ack_cycles = 0;
  int vs_period  = 800;
  int vs_ph      = 750;
  bit vs_run     = 1'b0;
  int falls[$];

  always @(posedge pixel_clk) cyc <= cyc + 1;
  always @(negedge pixel_clk) if (mode_ack === 1'b1) ack_cycles++;

  // Vsync source: low for 4 cycles every vs_period; logs each falling edge.
  initial begin
    vga_vs = 1'b1;
    forever begin
      @(negedge pixel_clk);
      if (vs_run) begin
        vs_ph = (vs_ph + 1) % vs_period;
        if (vs_ph == 0) falls.push_back(cyc);
        vga_vs = (vs_ph >= 4);
      end else begin
        vga_vs = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit timing_is(input int m);
    return h_disp == exp_hd[m] && h_fporch == exp_hf[m] && h_sync == exp_hs[m] &&
           h_bporch == exp_hb[m] && v_disp == exp_vd[m] && v_fporch == exp_vf[m] &&
           v_sync == exp_vs[m] && v_bporch == exp_vb[m] && current_mode == 2'(m);
  endfunction

  task automatic check_timing(input string tag, input int m);
    check({tag, " h_disp"},   h_disp,   exp_hd[m]);
    check({tag, " h_fporch"}, h_fporch, exp_hf[m]);
    check({tag, " h_sync"},   h_sync,   exp_hs[m]);
    check({tag, " h_bporch"}, h_bporch, exp_hb[m]);
    check({tag, " v_disp"},   v_disp,   exp_vd[m]);
    check({tag, " v_fporch"}, v_fporch, exp_vf[m]);
    check({tag, " v_sync"},   v_sync,   exp_vs[m]);
    check({tag, " v_bporch"}, v_bporch, exp_vb[m]);
    check({tag, " mode"},     current_mode, m);
  endtask

  // Park away from any vsync edge so request acceptance is unambiguous.
  task automatic wait_safe();
    for (int i = 0; i < 2000 && vs_run && vs_ph != 100; i++) @(negedge pixel_clk);
  endtask

  // Post-reset settle: blanked and busy until SETTLE falls, then IDLE, no ack.
  task automatic boot_check(input string tag, input int f0, input int ack0, output int drop);
    bit blank_ok;
    blank_ok = 1'b1;
    drop = -1;
    for (int i = 0; i < 4000 && drop < 0; i++) begin
      @(negedge pixel_clk);
      if (busy === 1'b0) drop = cyc;
      else if (blank_force !== 1'b1) blank_ok = 1'b0;
    end
    check({tag, " blank while settling"}, blank_ok, 1);
    check({tag, " settle end cycle"}, drop, (falls.size() > f0 + SETTLE - 1) ? falls[f0 + SETTLE - 1] + 3 : -1);
    check({tag, " no ack"}, ack_cycles, ack0);
    check({tag, " blank at idle"}, blank_force, 0);
    check({tag, " mode"}, current_mode, 0);
  endtask

  // Follows one accepted mode change through apply, settle and ack.
  task automatic run_change(input string tag, input int sel, input int old, input int acc,
                            input bit use_to, input bit drop_early, input bit toggle, input int tog_to);
    int apply_cyc, ack_cyc, ref_cyc, exp_ack, f0;
    bit pre_ok, post_ok, held_ok;
    apply_cyc = -1;
    ack_cyc   = -1;
    pre_ok    = 1'b1;
    post_ok   = 1'b1;
    f0        = falls.size();
    for (int i = 0; i < 8000 && ack_cyc < 0; i++) begin
      @(negedge pixel_clk);
      if (toggle && cyc == acc + 5) mode_sel = 2'(tog_to);
      if (drop_early && cyc == acc + 10) mode_req = 1'b0;
      if (mode_ack === 1'b1) begin
        ack_cyc = cyc;
      end else if (apply_cyc < 0) begin
        if (current_mode !== 2'(old)) begin
          apply_cyc = cyc;
          check_timing({tag, " apply"}, sel);
          check({tag, " blank at apply"}, blank_force, 1);
          if (use_to) check({tag, " flag at apply"}, timeout_flag, 1);
        end else if (!timing_is(old) || blank_force !== 1'b0 || busy !== 1'b1) begin
          pre_ok = 1'b0;
        end
      end else if (!timing_is(sel) || blank_force !== 1'b1 || busy !== 1'b1) begin
        post_ok = 1'b0;
      end
    end
    check({tag, " stable before apply"}, pre_ok, 1);
    check({tag, " blanked in settle"}, post_ok, 1);
    if (use_to) ref_cyc = acc + T_CYC;
    else        ref_cyc = (falls.size() > f0) ? falls[f0] + 3 : -100;
    check({tag, " apply in window"}, (apply_cyc >= ref_cyc && apply_cyc <= ref_cyc + 1), 1);
    if (use_to) exp_ack = apply_cyc + SETTLE * T_CYC;
    else        exp_ack = (falls.size() > f0 + SETTLE) ? falls[f0 + SETTLE] + 3 : -1;
    check({tag, " ack cycle"}, ack_cyc, exp_ack);
    check({tag, " timeout flag"}, timeout_flag, use_to);
    if (drop_early) begin
      @(negedge pixel_clk);
      check({tag, " ack single pulse"}, mode_ack, 0);
      check({tag, " idle after pulse"}, busy, 0);
    end else begin
      held_ok = 1'b1;
      repeat ($urandom_range(1, 4)) begin
        @(negedge pixel_clk);
        if (mode_ack !== 1'b1) held_ok = 1'b0;
      end
      check({tag, " ack held"}, held_ok, 1);
      mode_req = 1'b0;
      @(negedge pixel_clk);
      check({tag, " ack drop"}, mode_ack, 0);
      check({tag, " idle after ack"}, busy, 0);
    end
    check({tag, " unblanked"}, blank_force, 0);
    check({tag, " final timing"}, timing_is(sel), 1);
  endtask

  task automatic request(input string tag, input int sel, input bit use_to,
                         input bit drop_early, input bit toggle, input int tog_to);
    int acc, old;
    old      = exp_mode;
    mode_sel = 2'(sel);
    mode_req = 1'b1;
    acc      = cyc + 1;
    @(negedge pixel_clk);
    check({tag, " flag cleared"}, timeout_flag, 0);
    check({tag, " busy on accept"}, busy, 1);
    if (sel == old) begin
      check({tag, " same-mode ack"}, mode_ack, 1);
      check({tag, " same-mode no blank"}, blank_force, 0);
      check({tag, " same-mode timing"}, timing_is(old), 1);
      mode_req = 1'b0;
      @(negedge pixel_clk);
      check({tag, " same-mode ack drop"}, mode_ack, 0);
      check({tag, " same-mode idle"}, busy, 0);
    end else begin
      run_change(tag, sel, old, acc, use_to, drop_early, toggle, tog_to);
      exp_mode = sel;
    end
  endtask

  initial begin
    int f0, ack0, drop, sel;
    bit seen;
    reset_n  = 1'b0;
    mode_req = 1'b0;
    mode_sel = 2'd0;
    vs_run   = 1'b1;
    repeat (3) @(negedge pixel_clk);
    check_timing("reset", 0);
    check("reset blank", blank_force, 1);
    check("reset busy", busy, 1);
    check("reset ack", mode_ack, 0);
    check("reset flag", timeout_flag, 0);

    wait_safe();
    f0 = falls.size();
    reset_n = 1'b1;
    boot_check("boot", f0, 0, drop);

    wait_safe();
    request("m2", 2, 1'b0, 1'b0, 1'b0, 0);
    wait_safe();
    request("m2same", 2, 1'b0, 1'b0, 1'b0, 0);

    wait_safe();
    vs_run = 1'b0;
    request("tmo", 1, 1'b1, 1'b0, 1'b0, 0);
    vs_run = 1'b1;
    wait_safe();
    request("clr", 0, 1'b0, 1'b0, 1'b0, 0);
    wait_safe();
    request("tog", 1, 1'b0, 1'b1, 1'b1, 3);

    // Reset in the middle of a settle towards mode 3, request held throughout.
    wait_safe();
    mode_sel = 2'd3;
    mode_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge pixel_clk);
      if (current_mode === 2'd3) seen = 1'b1;
    end
    check("rst mode3 applied", seen, 1);
    repeat (20) @(negedge pixel_clk);
    ack0     = ack_cycles;
    mode_sel = 2'd1;
    reset_n  = 1'b0;
    #1;
    check_timing("rst async", 0);
    check("rst blank", blank_force, 1);
    check("rst busy", busy, 1);
    check("rst ack", mode_ack, 0);
    exp_mode = 0;
    repeat (5) @(negedge pixel_clk);
    wait_safe();
    f0 = falls.size();
    reset_n = 1'b1;
    boot_check("reboot", f0, ack0, drop);
    @(negedge pixel_clk);
    check("held req accepted", busy, 1);
    run_change("held", 1, 0, drop + 1, 1'b0, 1'b0, 1'b0, 0);
    exp_mode = 1;

    for (int k = 0; k < 6; k++) begin
      wait_safe();
      vs_period = 600 + 100 * int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 3));
      request($sformatf("rnd%0d", k), sel, 1'b0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 30)) @(negedge pixel_clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
